// File: rtl/ad9866_rx_deframer.sv
// AD9866 RX deframer: rebuilds 12-bit samples from 6-bit MSB/LSB words, tracks alignment lock and
// buffers samples in a FWFT FIFO. Define AD9866_RX_CLIP_DETECT_EN to add clip/clip_cnt statistics.
module ad9866_rx_deframer #(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       rx_nibble,
    input  logic             rx_sync,
    input  logic             rx_enable,
    output logic [11:0]      sample,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             locked,
    output logic [ERR_W-1:0] sync_err_cnt,
    output logic             fifo_overflow,
`ifdef AD9866_RX_CLIP_DETECT_EN
    output logic             clip,
    output logic [15:0]      clip_cnt,
`endif
    input  logic             clear_stats
);

    localparam int unsigned NIB_W  = 6;
    localparam int unsigned SMP_W  = 12;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    localparam logic [1:0] ST_HUNT     = 2'd0;
    localparam logic [1:0] ST_WAIT_LSB = 2'd1;
    localparam logic [1:0] ST_WAIT_MSB = 2'd2;

    logic [NIB_W-1:0] r_nib_q, r_nib_d;
    logic             r_sync_q, r_sync_d;
    logic [1:0]       state_q, state_d;
    logic [NIB_W-1:0] msb_q, msb_d;
    logic [CNT_W-1:0] good_q, good_d, good_inc;
    logic             locked_q, locked_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             ovf_q, ovf_d;
    logic [SMP_W-1:0] mem_q [FIFO_DEPTH];
    logic [SMP_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [SMP_W-1:0] sample_q, sample_d;
    logic             valid_q, valid_d;
    logic             push, sync_err, pop, full, wr_en;
    logic [SMP_W-1:0] push_data;

    // Alignment FSM operating on the registered RX word
    always_comb begin
        r_nib_d   = rx_nibble;
        r_sync_d  = rx_sync;
        state_d   = state_q;
        msb_d     = msb_q;
        good_d    = good_q;
        locked_d  = locked_q;
        push      = 1'b0;
        sync_err  = 1'b0;
        push_data = {msb_q, r_nib_q};
        good_inc  = (good_q >= CNT_W'(LOCK_CNT)) ? good_q : good_q + CNT_W'(1);
        if (!rx_enable) begin
            state_d  = ST_HUNT;
            good_d   = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (r_sync_q) begin
                        msb_d   = r_nib_q;
                        state_d = ST_WAIT_LSB;
                    end
                end
                ST_WAIT_LSB: begin
                    if (!r_sync_q) begin
                        good_d  = good_inc;
                        push    = locked_q || (good_inc == CNT_W'(LOCK_CNT));
                        if (good_inc == CNT_W'(LOCK_CNT)) locked_d = 1'b1;
                        state_d = ST_WAIT_MSB;
                    end else begin
                        // Repeated MSB: realign on the newest one
                        sync_err = 1'b1;
                        msb_d    = r_nib_q;
                        good_d   = '0;
                        locked_d = 1'b0;
                    end
                end
                ST_WAIT_MSB: begin
                    if (r_sync_q) begin
                        msb_d   = r_nib_q;
                        state_d = ST_WAIT_LSB;
                    end else begin
                        sync_err = 1'b1;
                        state_d  = ST_HUNT;
                        good_d   = '0;
                        locked_d = 1'b0;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // FWFT FIFO; head and valid are registered from the next-state pointers
    always_comb begin
        pop      = valid_q & sample_ready;
        full     = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) && (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
        wr_en    = push & (~full | pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        sample_d = mem_d[rd_ptr_d[PTR_W-1:0]];
        valid_d  = (wr_ptr_d != rd_ptr_d);
    end

    // Statistics; clear_stats wins over a coincident event
    always_comb begin
        err_d = err_q;
        ovf_d = ovf_q;
        if (clear_stats) begin
            err_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (sync_err && err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
            if (push && !wr_en) ovf_d = 1'b1;
        end
    end

`ifdef AD9866_RX_CLIP_DETECT_EN
    logic        clip_q, clip_d;
    logic [15:0] clip_cnt_q, clip_cnt_d;

    // Full-scale detection counts every pushed sample, dropped or not
    always_comb begin
        clip_d     = clip_q;
        clip_cnt_d = clip_cnt_q;
        if (clear_stats) begin
            clip_d     = 1'b0;
            clip_cnt_d = '0;
        end else if (push && (push_data == 12'h7FF || push_data == 12'h800)) begin
            clip_d = 1'b1;
            if (clip_cnt_q != 16'hFFFF) clip_cnt_d = clip_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clip_q     <= 1'b0;
            clip_cnt_q <= '0;
        end else begin
            clip_q     <= clip_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign clip     = clip_q;
    assign clip_cnt = clip_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nib_q  <= '0;
            r_sync_q <= 1'b0;
            state_q  <= ST_HUNT;
            msb_q    <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= '0;
            ovf_q    <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            r_nib_q  <= r_nib_d;
            r_sync_q <= r_sync_d;
            state_q  <= state_d;
            msb_q    <= msb_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign sample        = sample_q;
    assign sample_valid  = valid_q;
    assign locked        = locked_q;
    assign sync_err_cnt  = err_q;
    assign fifo_overflow = ovf_q;

endmodule
